// File: rtl/aidc_lite_comp_pkg.sv
// Shared types, sizes and helpers for the AIDC-Lite compressor scheduler.
package aidc_lite_comp_pkg;

  localparam int unsigned BLK_BYTES = 128;
  localparam int unsigned BEATS     = 16;
  localparam int unsigned BEAT_W    = 64;
  localparam int unsigned SIZE_W    = 8;
  localparam int unsigned ADDR_W    = $clog2(BEATS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM,
    ST_WAIT_DONE,
    ST_REPORT
  } sched_state_t;

  // Compressed sizes above one block are clamped to the raw block size.
  function automatic logic [SIZE_W-1:0] sat_size(input logic [SIZE_W-1:0] s);
    return (s > SIZE_W'(BLK_BYTES)) ? SIZE_W'(BLK_BYTES) : s;
  endfunction

endpackage

// File: rtl/aidc_lite_comp_sched_if.sv
// Engine / staging-buffer / compressor signals seen by the scheduler.
interface aidc_lite_comp_sched_if;
  import aidc_lite_comp_pkg::*;

  logic              blk_valid_i;
  logic              blk_ready_o;
  logic              buf_rden_o;
  logic [ADDR_W-1:0] buf_raddr_o;
  logic [BEAT_W-1:0] buf_rdata_i;
  logic              comp_start_o;
  logic              comp_ready_i;
  logic              comp_wvalid_o;
  logic              comp_wready_i;
  logic [BEAT_W-1:0] comp_wdata_o;
  logic              comp_wlast_o;
  logic              comp_done_i;
  logic [SIZE_W-1:0] comp_size_i;
  logic              blk_done_o;
  logic [SIZE_W-1:0] blk_size_o;
  logic              blk_comp_o;
  logic              blk_err_o;

  modport master (
    input  blk_valid_i, buf_rdata_i, comp_ready_i, comp_wready_i, comp_done_i, comp_size_i,
    output blk_ready_o, buf_rden_o, buf_raddr_o, comp_start_o, comp_wvalid_o, comp_wdata_o,
           comp_wlast_o, blk_done_o, blk_size_o, blk_comp_o, blk_err_o
  );

  modport slave (
    output blk_valid_i, buf_rdata_i, comp_ready_i, comp_wready_i, comp_done_i, comp_size_i,
    input  blk_ready_o, buf_rden_o, buf_raddr_o, comp_start_o, comp_wvalid_o, comp_wdata_o,
           comp_wlast_o, blk_done_o, blk_size_o, blk_comp_o, blk_err_o
  );

endinterface

// File: rtl/aidc_lite_skid_fifo.sv
// 2-entry fall-through skid FIFO: a push into an empty FIFO is visible at the head
// in the same cycle, so full-rate streaming needs no extra bubble.
module aidc_lite_skid_fifo
  import aidc_lite_comp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [BEAT_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_c,
  output logic [BEAT_W-1:0] head_c,
  output logic [1:0]        count_o
);

  logic [BEAT_W-1:0] mem_q [2];
  logic [BEAT_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              empty_c, wr_en_c, rd_en_c;

  always_comb begin
    empty_c  = (count_q == 2'd0);
    // A push popped in the same cycle while empty bypasses storage entirely.
    wr_en_c  = push_i & ~(empty_c & pop_i);
    rd_en_c  = pop_i & ~empty_c;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ wr_en_c;
    rd_ptr_d = rd_ptr_q ^ rd_en_c;
    count_d  = count_q + 2'(wr_en_c) - 2'(rd_en_c);
    if (wr_en_c) mem_d[wr_ptr_q] = push_data_i;
    if (clr_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid_c = ~empty_c | push_i;
  assign head_c  = empty_c ? push_data_i : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/aidc_lite_comp_sched.sv
// Sequences one 128 B staged block into the compressor and reports its compressed size.
module aidc_lite_comp_sched
  import aidc_lite_comp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aidc_lite_comp_sched_if.master bus
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT);
  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned OCC_W = 3;

  sched_state_t      state_q, state_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              rd_inflight_q;
  logic [SIZE_W-1:0] cap_size_q, cap_size_d;
  logic              cap_err_q, cap_err_d;
  logic              blk_done_q, blk_done_d;
  logic [SIZE_W-1:0] blk_size_q, blk_size_d;
  logic              blk_comp_q, blk_comp_d;
  logic              blk_err_q, blk_err_d;

  logic              fifo_clr_c, fifo_valid_c, pop_c, rden_c;
  logic [BEAT_W-1:0] fifo_head_c;
  logic [1:0]        fifo_count;
  logic [OCC_W-1:0]  occ_c;

  aidc_lite_skid_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (fifo_clr_c),
    .push_i      (rd_inflight_q),
    .push_data_i (bus.buf_rdata_i),
    .pop_i       (pop_c),
    .valid_c     (fifo_valid_c),
    .head_c      (fifo_head_c),
    .count_o     (fifo_count)
  );

  // Issue a read only if the data it returns next cycle is guaranteed a FIFO slot.
  always_comb begin
    pop_c  = fifo_valid_c & bus.comp_wready_i;
    occ_c  = OCC_W'(fifo_count) + OCC_W'(rd_inflight_q) - OCC_W'(pop_c);
    rden_c = (state_q == ST_STREAM) && !rd_ptr_q[ADDR_W] && (occ_c < OCC_W'(2));
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    to_cnt_d   = to_cnt_q;
    cap_size_d = cap_size_q;
    cap_err_d  = cap_err_q;
    blk_done_d = 1'b0;
    blk_size_d = blk_size_q;
    blk_comp_d = blk_comp_q;
    blk_err_d  = blk_err_q;
    fifo_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.blk_valid_i) begin
          state_d    = ST_START;
          rd_ptr_d   = '0;
          beat_cnt_d = '0;
          fifo_clr_c = 1'b1;
        end
      end
      ST_START: begin
        if (bus.comp_ready_i) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (rden_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (pop_c) begin
          beat_cnt_d = beat_cnt_q + ADDR_W'(1);
          if (beat_cnt_q == ADDR_W'(BEATS - 1)) begin
            state_d  = ST_WAIT_DONE;
            to_cnt_d = '0;
          end
        end
      end
      ST_WAIT_DONE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (bus.comp_done_i) begin
          cap_size_d = sat_size(bus.comp_size_i);
          cap_err_d  = 1'b0;
          state_d    = ST_REPORT;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          cap_size_d = SIZE_W'(BLK_BYTES);
          cap_err_d  = 1'b1;
          state_d    = ST_REPORT;
        end
      end
      ST_REPORT: begin
        // Stay until the registered done pulse has been issued.
        if (blk_done_q) begin
          state_d = ST_IDLE;
        end else begin
          blk_done_d = 1'b1;
          blk_size_d = cap_size_q;
          blk_comp_d = (cap_size_q < SIZE_W'(BLK_BYTES));
          blk_err_d  = cap_err_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rd_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      to_cnt_q      <= '0;
      rd_inflight_q <= 1'b0;
      cap_size_q    <= '0;
      cap_err_q     <= 1'b0;
      blk_done_q    <= 1'b0;
      blk_size_q    <= '0;
      blk_comp_q    <= 1'b0;
      blk_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      to_cnt_q      <= to_cnt_d;
      rd_inflight_q <= rden_c;
      cap_size_q    <= cap_size_d;
      cap_err_q     <= cap_err_d;
      blk_done_q    <= blk_done_d;
      blk_size_q    <= blk_size_d;
      blk_comp_q    <= blk_comp_d;
      blk_err_q     <= blk_err_d;
    end
  end

  assign bus.blk_ready_o   = (state_q == ST_IDLE);
  assign bus.comp_start_o  = (state_q == ST_START);
  assign bus.buf_rden_o    = rden_c;
  assign bus.buf_raddr_o   = rden_c ? rd_ptr_q[ADDR_W-1:0] : '0;
  assign bus.comp_wvalid_o = fifo_valid_c;
  assign bus.comp_wdata_o  = fifo_valid_c ? fifo_head_c : '0;
  assign bus.comp_wlast_o  = fifo_valid_c && (beat_cnt_q == ADDR_W'(BEATS - 1));
  assign bus.blk_done_o    = blk_done_q;
  assign bus.blk_size_o    = blk_size_q;
  assign bus.blk_comp_o    = blk_comp_q;
  assign bus.blk_err_o     = blk_err_q;

endmodule

// File: tb/tb_aidc_lite_comp_sched.sv
// Directed bench for aidc_lite_comp_sched; a second instance with a short timeout
// shares all inputs except its own staging-buffer model.
module tb_aidc_lite_comp_sched;
  import aidc_lite_comp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aidc_lite_comp_sched_if ifa ();
  aidc_lite_comp_sched_if ifb ();

  aidc_lite_comp_sched #(.TIMEOUT(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(ifa));
  aidc_lite_comp_sched #(.TIMEOUT(8))  u_dut_to (.clk(clk), .rst_n(rst_n), .bus(ifb));

  assign ifb.blk_valid_i   = ifa.blk_valid_i;
  assign ifb.comp_ready_i  = ifa.comp_ready_i;
  assign ifb.comp_wready_i = ifa.comp_wready_i;
  assign ifb.comp_done_i   = ifa.comp_done_i;
  assign ifb.comp_size_i   = ifa.comp_size_i;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [7:0] cur_tag = 8'h00;
  bit rand_w = 1'b0;

  function automatic logic [63:0] entry(input logic [7:0] tag, input logic [3:0] k);
    return {tag, 24'h5A5A5A, 28'h0, k};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Staging buffers: registered read, data valid the cycle after rden.
  always @(posedge clk) begin
    ifa.buf_rdata_i <= ifa.buf_rden_o ? entry(cur_tag, ifa.buf_raddr_o) : 64'hBAD0_BAD0_BAD0_BAD0;
    ifb.buf_rdata_i <= ifb.buf_rden_o ? entry(cur_tag, ifb.buf_raddr_o) : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  always @(posedge clk) begin
    #1 ifa.comp_wready_i = rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor, sampled on the falling edge.
  logic [63:0] beat_data[$];
  int          beat_cyc[$];
  bit          beat_last[$];
  int          rd_addr[$];
  int          rd_cyc[$];
  int t_hs, start_cnt, start_stall, stall_viol, done_cnt, done_cyc, ready_rise, wait_entry;
  int b_done_cnt, b_done_cyc;
  logic [7:0] done_size, b_size;
  logic done_comp, done_err, b_comp, b_err;
  bit prev_stall = 1'b0;
  bit prev_ready = 1'b1;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.blk_valid_i && ifa.blk_ready_o) t_hs = cyc;
      if (ifa.comp_start_o) begin
        start_cnt++;
        if (!ifa.comp_ready_i) start_stall++;
      end
      if (ifa.buf_rden_o) begin
        rd_addr.push_back(int'(ifa.buf_raddr_o));
        rd_cyc.push_back(cyc);
      end
      if (prev_stall && (!ifa.comp_wvalid_o || ifa.comp_wdata_o != prev_data)) stall_viol++;
      prev_stall = ifa.comp_wvalid_o && !ifa.comp_wready_i;
      prev_data  = ifa.comp_wdata_o;
      if (ifa.comp_wvalid_o && ifa.comp_wready_i) begin
        beat_data.push_back(ifa.comp_wdata_o);
        beat_cyc.push_back(cyc);
        beat_last.push_back(ifa.comp_wlast_o);
        if (ifa.comp_wlast_o) wait_entry = cyc + 1;
      end
      if (ifa.blk_done_o) begin
        done_cnt++;
        done_cyc  = cyc;
        done_size = ifa.blk_size_o;
        done_comp = ifa.blk_comp_o;
        done_err  = ifa.blk_err_o;
      end
      if (ifa.blk_ready_o && !prev_ready) ready_rise = cyc;
      prev_ready = ifa.blk_ready_o;
      if (ifb.blk_done_o) begin
        b_done_cnt++;
        b_done_cyc = cyc;
        b_size     = ifb.blk_size_o;
        b_comp     = ifb.blk_comp_o;
        b_err      = ifb.blk_err_o;
      end
    end else begin
      prev_stall = 1'b0;
      prev_ready = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    beat_data.delete(); beat_cyc.delete(); beat_last.delete();
    rd_addr.delete(); rd_cyc.delete();
    t_hs = -1; start_cnt = 0; start_stall = 0; stall_viol = 0;
    done_cnt = 0; done_cyc = -1; ready_rise = -1; wait_entry = -1;
    b_done_cnt = 0; b_done_cyc = -1;
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, ".ready"},  64'(ifa.blk_ready_o),   64'd1);
    chk({nm, ".start"},  64'(ifa.comp_start_o),  64'd0);
    chk({nm, ".wvalid"}, 64'(ifa.comp_wvalid_o), 64'd0);
    chk({nm, ".wlast"},  64'(ifa.comp_wlast_o),  64'd0);
    chk({nm, ".rden"},   64'(ifa.buf_rden_o),    64'd0);
    chk({nm, ".raddr"},  64'(ifa.buf_raddr_o),   64'd0);
    chk({nm, ".wdata"},  ifa.comp_wdata_o,       64'd0);
    chk({nm, ".done"},   64'(ifa.blk_done_o),    64'd0);
    chk({nm, ".size"},   64'(ifa.blk_size_o),    64'd0);
    chk({nm, ".comp"},   64'(ifa.blk_comp_o),    64'd0);
    chk({nm, ".err"},    64'(ifa.blk_err_o),     64'd0);
  endtask

  task automatic send_block(input string nm, input logic [7:0] tag);
    bit ok;
    ok = 1'b0;
    cur_tag = tag;
    ifa.blk_valid_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (t_hs >= 0) begin
        ok = 1'b1;
        break;
      end
    end
    ifa.blk_valid_i = 1'b0;
    if (!ok) chk({nm, ".blk_handshake"}, 64'd0, 64'd1);
  endtask

  task automatic wait_beats(input string nm, input int n, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (beat_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (!ok) chk({nm, ".beat_wait"}, 64'(beat_data.size()), 64'(n));
  endtask

  // One block: optional start stall, optional random wready, done pulse done_dly cycles
  // after the last beat.
  task automatic run_block(input string nm, input logic [7:0] tag, input int stall,
                           input bit rnd, input int done_dly, input logic [7:0] size,
                           input logic [7:0] exp_size, input bit exp_comp, input bit chk_b);
    int d_cyc;
    int nb;
    clear_mon();
    ifa.comp_ready_i = (stall == 0);
    rand_w = rnd;
    send_block(nm, tag);
    if (stall > 0) begin
      tick(stall);
      ifa.comp_ready_i = 1'b1;
    end
    wait_beats(nm, 16, 400);
    rand_w = 1'b0;
    tick(done_dly - 1);
    ifa.comp_done_i = 1'b1;
    ifa.comp_size_i = size;
    d_cyc = cyc;
    tick(1);
    ifa.comp_done_i = 1'b0;
    ifa.comp_size_i = 8'h00;
    for (int i = 0; i < 20 && ready_rise < 0; i++) tick(1);

    nb = (beat_data.size() < 16) ? beat_data.size() : 16;
    chk({nm, ".beats"}, 64'(beat_data.size()), 64'd16);
    for (int k = 0; k < nb; k++) begin
      chk($sformatf("%s.data%0d", nm, k), beat_data[k], entry(tag, 4'(k)));
      chk($sformatf("%s.wlast%0d", nm, k), 64'(beat_last[k]), 64'(k == 15));
      if (!rnd) chk($sformatf("%s.beat_cyc%0d", nm, k), 64'(beat_cyc[k] - t_hs), 64'(3 + k));
    end
    chk({nm, ".rden_cnt"}, 64'(rd_addr.size()), 64'd16);
    for (int k = 0; k < rd_addr.size() && k < 16; k++)
      chk($sformatf("%s.raddr%0d", nm, k), 64'(rd_addr[k]), 64'(k));
    if (stall == 0 && !rnd && rd_cyc.size() > 0)
      chk({nm, ".first_rden"}, 64'(rd_cyc[0] - t_hs), 64'd2);
    chk({nm, ".start_cyc"}, 64'(start_cnt), 64'(stall + 1));
    chk({nm, ".start_stall"}, 64'(start_stall), 64'(stall));
    chk({nm, ".stable"}, 64'(stall_viol), 64'd0);
    chk({nm, ".done_cnt"}, 64'(done_cnt), 64'd1);
    chk({nm, ".done_lat"}, 64'(done_cyc - d_cyc), 64'd2);
    chk({nm, ".idle_lat"}, 64'(ready_rise - d_cyc), 64'd3);
    chk({nm, ".size"}, 64'(done_size), 64'(exp_size));
    chk({nm, ".comp"}, 64'(done_comp), 64'(exp_comp));
    chk({nm, ".err"},  64'(done_err), 64'd0);
    chk({nm, ".size_hold"}, 64'(ifa.blk_size_o), 64'(exp_size));
    if (chk_b) begin
      chk({nm, ".b_done_cnt"}, 64'(b_done_cnt), 64'd1);
      chk({nm, ".b_done_lat"}, 64'(b_done_cyc - d_cyc), 64'd2);
      chk({nm, ".b_size"}, 64'(b_size), 64'(exp_size));
      chk({nm, ".b_err"}, 64'(b_err), 64'd0);
    end
    tick(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    ifa.blk_valid_i  = 1'b0;
    ifa.comp_ready_i = 1'b1;
    ifa.comp_done_i  = 1'b0;
    ifa.comp_size_i  = 8'h00;
    clear_mon();
    tick(3);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick(2);
    check_idle_outputs("post_reset");

    run_block("nominal", 8'h01, 0, 1'b0, 10, 8'h40, 8'h40, 1'b1, 1'b0);
    run_block("backpr",  8'h02, 5, 1'b1, 4,  8'h25, 8'h25, 1'b1, 1'b0);
    run_block("incomp",  8'h03, 0, 1'b0, 10, 8'h80, 8'h80, 1'b0, 1'b0);
    run_block("satur",   8'h04, 0, 1'b0, 10, 8'hC8, 8'h80, 1'b0, 1'b0);
    run_block("zero",    8'h05, 0, 1'b0, 10, 8'h00, 8'h00, 1'b1, 1'b0);

    // Timeout: no done. Short-timeout instance reports after 8 WAIT_DONE cycles.
    clear_mon();
    send_block("timeout", 8'h06);
    wait_beats("timeout", 16, 100);
    for (int i = 0; i < 30 && b_done_cnt == 0; i++) tick(1);
    for (int i = 0; i < 60 && done_cnt == 0; i++) tick(1);
    chk("timeout.b_done_cnt", 64'(b_done_cnt), 64'd1);
    chk("timeout.b_lat", 64'(b_done_cyc - wait_entry), 64'd9);
    chk("timeout.b_err", 64'(b_err), 64'd1);
    chk("timeout.b_size", 64'(b_size), 64'h80);
    chk("timeout.b_comp", 64'(b_comp), 64'd0);
    chk("timeout.a_lat", 64'(done_cyc - wait_entry), 64'd33);
    chk("timeout.a_err", 64'(done_err), 64'd1);
    chk("timeout.a_size", 64'(done_size), 64'h80);
    tick(3);
    run_block("after_to", 8'h07, 0, 1'b0, 3, 8'h20, 8'h20, 1'b1, 1'b1);

    // Spurious done during STREAM, then reset while beat 7 is on the bus.
    clear_mon();
    send_block("spur", 8'h08);
    wait_beats("spur", 3, 50);
    ifa.comp_done_i = 1'b1;
    ifa.comp_size_i = 8'h11;
    tick(1);
    ifa.comp_done_i = 1'b0;
    ifa.comp_size_i = 8'h00;
    wait_beats("spur", 7, 50);
    chk("spur.beat7", ifa.comp_wdata_o, entry(8'h08, 4'd7));
    chk("spur.no_done", 64'(done_cnt), 64'd0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(1);
    run_block("post_rst", 8'h09, 0, 1'b0, 10, 8'h33, 8'h33, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
